// File: rtl/fp_tap_accumulator.sv
// fp_tap_accumulator: multi-cycle IEEE-754 single-precision sum of the
// per-tap products of one IIR output sample. One term is folded into the
// accumulator every four cycles (IDLE accept, ALIGN, ADD, NORM); the
// finished sum is held on acc_data under a valid/ready handshake.
// Rounding is toward zero and denormals are flushed to zero.
// Optional macro FP_ACC_STATUS_EN adds status[2:0] = {nan, overflow, underflow}.
module fp_tap_accumulator #(
    parameter int MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        acc_valid,
    output logic [31:0] acc_data,
    input  logic        acc_ready,
    output logic [7:0]  term_count
`ifdef FP_ACC_STATUS_EN
    ,
    output logic [2:0]  status
`endif
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] acc_q, in_q;
    logic        last_q;
    logic        big_s_q, sub_q, spec_s_q;
    logic [7:0]  big_e_q;
    logic [25:0] big_m_q, sml_m_q;
    logic [1:0]  spec_q;
    logic [26:0] sum_q;
    logic        flag_nan_q, flag_ovf_q, flag_unf_q;

    // ALIGN-stage operand unpack: a = accumulator, b = new product
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [7:0]  ea, eb, ediff;
    logic [22:0] fa, fb;
    logic [25:0] ma, mb, sml_pre, sml_sh;
    logic [1:0]  spec_d;
    logic        spec_s_d;

    assign {sa, ea, fa} = acc_q;
    assign {sb, eb, fb} = in_q;

    // Unpack, classify specials and align the smaller magnitude
    always_comb begin
        ma      = (ea == 8'd0) ? 26'd0 : {1'b1, fa, 2'b00};
        mb      = (eb == 8'd0) ? 26'd0 : {1'b1, fb, 2'b00};
        a_nan   = (ea == 8'hFF) && (fa != 23'd0);
        b_nan   = (eb == 8'hFF) && (fb != 23'd0);
        a_inf   = (ea == 8'hFF) && (fa == 23'd0);
        b_inf   = (eb == 8'hFF) && (fb == 23'd0);
        a_big   = {ea, ma} >= {eb, mb};
        ediff   = a_big ? (ea - eb) : (eb - ea);
        sml_pre = a_big ? mb : ma;
        sml_sh  = (ediff >= 8'd26) ? 26'd0 : (sml_pre >> ediff);
        spec_d   = SP_NONE;
        spec_s_d = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_d = SP_NAN;
        end else if (a_inf) begin
            spec_d   = SP_INF;
            spec_s_d = sa;
        end else if (b_inf) begin
            spec_d   = SP_INF;
            spec_s_d = sb;
        end
    end

    // NORM-stage leading-zero count: last hit wins, so the MSB has priority
    logic [4:0] lz;
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (sum_q[i]) lz = 5'(25 - i);
        end
    end

    logic [25:0]       shifted;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic [31:0]       norm_res;
    logic              norm_nan, norm_ovf, norm_unf;
    logic [2:0]        unused_bits;

    assign shifted     = sum_q[25:0] << lz;
    assign unused_bits = {shifted[25], shifted[1:0]};

    // Normalize, truncate guard bits and map to the packed result
    always_comb begin
        frac     = sum_q[26] ? sum_q[25:3] : shifted[24:2];
        exp_n    = sum_q[26] ? ($signed({2'b00, big_e_q}) + 10'sd1)
                             : ($signed({2'b00, big_e_q}) - $signed({5'd0, lz}));
        norm_res = 32'd0;
        norm_nan = 1'b0;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (spec_q == SP_NAN) begin
            norm_res = 32'h7FC0_0000;
            norm_nan = 1'b1;
        end else if (spec_q == SP_INF) begin
            norm_res = {spec_s_q, 8'hFF, 23'd0};
        end else if (sum_q == 27'd0) begin
            norm_res = 32'd0;
        end else if (exp_n >= 10'sd255) begin
            norm_res = {big_s_q, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            norm_res = 32'd0;
            norm_unf = 1'b1;
        end else begin
            norm_res = {big_s_q, exp_n[7:0], frac};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        acc_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ALIGN;
            end
            ALIGN: state_d = ADD;
            ADD:   state_d = NORM;
            NORM:  state_d = last_q ? OUT : IDLE;
            OUT: begin
                acc_valid = 1'b1;
                if (acc_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: one stage of work per state
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= 32'd0;
            in_q       <= 32'd0;
            last_q     <= 1'b0;
            big_s_q    <= 1'b0;
            big_e_q    <= 8'd0;
            big_m_q    <= 26'd0;
            sml_m_q    <= 26'd0;
            sub_q      <= 1'b0;
            spec_q     <= SP_NONE;
            spec_s_q   <= 1'b0;
            sum_q      <= 27'd0;
            acc_data   <= 32'd0;
            term_count <= 8'd0;
            flag_nan_q <= 1'b0;
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    in_q       <= in_data;
                    last_q     <= in_last || (term_count == 8'(MAX_TERMS - 1));
                    term_count <= term_count + 8'd1;
                end
                ALIGN: begin
                    big_s_q  <= a_big ? sa : sb;
                    big_e_q  <= a_big ? ea : eb;
                    big_m_q  <= a_big ? ma : mb;
                    sml_m_q  <= sml_sh;
                    sub_q    <= sa ^ sb;
                    spec_q   <= spec_d;
                    spec_s_q <= spec_s_d;
                end
                ADD: sum_q <= sub_q ? ({1'b0, big_m_q} - {1'b0, sml_m_q})
                                    : ({1'b0, big_m_q} + {1'b0, sml_m_q});
                NORM: begin
                    acc_q      <= norm_res;
                    flag_nan_q <= flag_nan_q | norm_nan;
                    flag_ovf_q <= flag_ovf_q | norm_ovf;
                    flag_unf_q <= flag_unf_q | norm_unf;
                    if (last_q) acc_data <= norm_res;
                end
                OUT: if (acc_ready) begin
                    acc_q      <= 32'd0;
                    term_count <= 8'd0;
                    flag_nan_q <= 1'b0;
                    flag_ovf_q <= 1'b0;
                    flag_unf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FP_ACC_STATUS_EN
    assign status = {flag_nan_q, flag_ovf_q, flag_unf_q};
`endif

endmodule

// File: tb/tb_fp_tap_accumulator.sv
// Directed bench for fp_tap_accumulator (MAX_TERMS = 4). Inputs change at
// the negedge or just after a posedge; outputs are sampled at the negedge.
module tb_fp_tap_accumulator;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, acc_ready;
    logic [31:0] in_data;
    logic        in_ready, acc_valid;
    logic [31:0] acc_data;
    logic [7:0]  term_count;
`ifdef FP_ACC_STATUS_EN
    logic [2:0]  status;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_tap_accumulator #(.MAX_TERMS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .acc_valid(acc_valid),
        .acc_data(acc_data), .acc_ready(acc_ready), .term_count(term_count)
`ifdef FP_ACC_STATUS_EN
        , .status(status)
`endif
    );

    // Offer one product and return just after the edge that accepts it
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Wait for acc_valid; lat counts negedges since the accept edge
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!acc_valid && lat < 40);
        if (!acc_valid) begin
            vectors++; miscompares++;
            $display("FAIL wait_valid_timeout: acc_valid=%b required 1", acc_valid);
        end
    endtask

    task automatic take();
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        vectors++; if (acc_valid !== 1'b0) begin miscompares++; $display("FAIL rst_acc_valid: got %b want 0", acc_valid); end
        vectors++; if (acc_data !== 32'h0) begin miscompares++; $display("FAIL rst_acc_data: got %h want 00000000", acc_data); end
        vectors++; if (term_count !== 8'd0) begin miscompares++; $display("FAIL rst_term_count: got %0d want 0", term_count); end
        rst = 1'b0;
    endtask

    task automatic test_basic_sum();
        int lat;
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_valid(lat);
        // Accept cycle, then ALIGN/ADD/NORM; valid in the fourth cycle after accept
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", lat); end
        vectors++; if (acc_data !== 32'h4040_0000) begin miscompares++; $display("FAIL basic_sum: got %h want 40400000", acc_data); end
        vectors++; if (term_count !== 8'd2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", term_count); end
`ifdef FP_ACC_STATUS_EN
        vectors++; if (status !== 3'b000) begin miscompares++; $display("FAIL basic_status: got %b want 000", status); end
`endif
        take();
        @(negedge clk);
        vectors++; if (acc_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop: got %b want 0", acc_valid); end
        vectors++; if (acc_data !== 32'h4040_0000) begin miscompares++; $display("FAIL basic_data_hold: got %h want 40400000", acc_data); end
        vectors++; if (term_count !== 8'd0) begin miscompares++; $display("FAIL basic_count_clear: got %0d want 0", term_count); end
    endtask

    task automatic test_cancel();
        int lat;
        send(32'h3F80_0000, 1'b0);
        send(32'hBF80_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h0) begin miscompares++; $display("FAIL cancel_sum: got %h want 00000000", acc_data); end
`ifdef FP_ACC_STATUS_EN
        vectors++; if (status !== 3'b000) begin miscompares++; $display("FAIL cancel_status: got %b want 000", status); end
`endif
        take();
    endtask

    task automatic test_align();
        int lat;
        // 1.0 shifted right by 24 lands only in the guard bits and is truncated
        send(32'h4B80_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h4B80_0000) begin miscompares++; $display("FAIL align_trunc: got %h want 4B800000", acc_data); end
        take();
        send(32'hC0A0_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'hC0A0_0000) begin miscompares++; $display("FAIL single_neg: got %h want C0A00000", acc_data); end
        take();
        send(32'h8000_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h0) begin miscompares++; $display("FAIL neg_zero: got %h want 00000000", acc_data); end
        take();
    endtask

    task automatic test_special();
        int lat;
        send(32'h7F7F_FFFF, 1'b0);
        send(32'h7F7F_FFFF, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h7F80_0000) begin miscompares++; $display("FAIL overflow_sum: got %h want 7F800000", acc_data); end
`ifdef FP_ACC_STATUS_EN
        vectors++; if (status !== 3'b010) begin miscompares++; $display("FAIL overflow_status: got %b want 010", status); end
`endif
        take();
        send(32'h7F80_0000, 1'b0);
        send(32'hFF80_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h7FC0_0000) begin miscompares++; $display("FAIL inf_minus_inf: got %h want 7FC00000", acc_data); end
`ifdef FP_ACC_STATUS_EN
        vectors++; if (status !== 3'b100) begin miscompares++; $display("FAIL nan_status: got %b want 100", status); end
`endif
        take();
        // NaN stays sticky through a later finite term
        send(32'h7FC0_0001, 1'b0);
        send(32'h3F80_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h7FC0_0000) begin miscompares++; $display("FAIL nan_sticky: got %h want 7FC00000", acc_data); end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        for (int i = 0; i < 4; i++) send(32'h3F80_0000, 1'b0);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h4080_0000) begin miscompares++; $display("FAIL implicit_last_sum: got %h want 40800000", acc_data); end
        vectors++; if (term_count !== 8'd4) begin miscompares++; $display("FAIL implicit_last_count: got %0d want 4", term_count); end
        in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1; acc_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (acc_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_%0d: got %b want 1", k, acc_valid); end
            vectors++; if (acc_data !== 32'h4080_0000) begin miscompares++; $display("FAIL bp_data_%0d: got %h want 40800000", k, acc_data); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
        end
        take();
        @(negedge clk);
        vectors++; if (term_count !== 8'd0) begin miscompares++; $display("FAIL bp_not_consumed: got %0d want 0", term_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        vectors++; if (term_count !== 8'd1) begin miscompares++; $display("FAIL bp_pending_taken: got %0d want 1", term_count); end
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h4000_0000) begin miscompares++; $display("FAIL bp_pending_sum: got %h want 40000000", acc_data); end
        take();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        @(negedge clk);           // ALIGN
        @(negedge clk);           // ADD
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (acc_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", acc_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        vectors++; if (term_count !== 8'd0) begin miscompares++; $display("FAIL mid_rst_count: got %0d want 0", term_count); end
        send(32'h4000_0000, 1'b1);
        wait_valid(lat);
        vectors++; if (acc_data !== 32'h4000_0000) begin miscompares++; $display("FAIL mid_rst_fresh: got %h want 40000000", acc_data); end
        take();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; acc_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_cancel();
        test_align();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
